mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle control unit that sequences the shared 32-bit ALU (add or equality compare, selected by a single `ALUctrl` bit) and the register file/PC for the minimal RV32I subset `addi` and `bne`. It owns the instruction register, decodes each fetched word, steers the ALU operand mux and operation, samples the ALU `EQ` flag, and issues the PC and register-file write strobes. It also maintains a retired-instruction counter. It sits between instruction memory and the existing ALU/regfile/PC datapath.

## Interface
- `DATA_WIDTH`, 32, instruction/IR width
- `CNT_WIDTH`, 32, retired-instruction counter width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  run enable, sampled only in FETCH
- `instr`  in  DATA_WIDTH  instruction-memory read data at current PC (combinational)
- `EQ`  in  1  ALU equality flag
- `IR`  out  DATA_WIDTH  latched instruction
- `ALUctrl`  out  1  1 = add, 0 = compare
- `ALUsrc`  out  1  1 = immediate operand 2, 0 = rs2
- `ImmSrc`  out  1  0 = I-type immediate, 1 = B-type immediate
- `RegWrite`  out  1  register-file write strobe
- `PCWrite`  out  1  PC update strobe
- `PCsrc`  out  1  0 = PC+4, 1 = PC+imm
- `illegal`  out  1  sticky unsupported-instruction flag
- `retired`  out  CNT_WIDTH  instructions completed

## Operation
- States: FETCH, DECODE, EXEC, WB, BRANCH, HALT.
- FETCH:
  - If `en`=1: `IRWrite` (internal) loads `instr` into IR, then go to DECODE.
  - If `en`=0: stay in FETCH; IR unchanged.
- DECODE: classify IR.
  - `opcode==7'b0010011` and `funct3==3'b000` → ADDI.
  - `opcode==7'b1100011` and `funct3==3'b001` → BNE.
  - Anything else → set `illegal`, go to HALT.
  - ADDI/BNE go to EXEC.
- EXEC:
  - ADDI: `ALUctrl`=1, `ALUsrc`=1, `ImmSrc`=0; next state WB.
  - BNE: `ALUctrl`=0, `ALUsrc`=0, `ImmSrc`=1; `EQ` registered into `eq_q` at the end of EXEC; next state BRANCH.
- WB: `RegWrite`=1, `PCWrite`=1, `PCsrc`=0, `ALUctrl`=1, `ALUsrc`=1 (operands held stable); next state FETCH.
- BRANCH: `PCWrite`=1, `PCsrc`=~`eq_q`, `ImmSrc`=1; next state FETCH.
- HALT: all strobes 0; stays in HALT until `rst`; `illegal` stays 1.
- `retired` increments by 1 on every cycle where `PCWrite`=1; wraps to 0 at all-ones, no saturation.
- Outputs are Moore (decoded from state and the registered instruction class), except `PCsrc`, which uses the registered `eq_q`. No output depends combinationally on `instr` or `EQ`.

## Timing
- Reset, next edge after `rst`=1:
  - state=FETCH, IR=0, `eq_q`=0, `illegal`=0, `retired`=0.
  - While `rst`=1, all strobes (`RegWrite`, `PCWrite`, internal `IRWrite`) are forced to 0, and `ALUctrl`/`ALUsrc`/`ImmSrc`/`PCsrc`=0.
- Latency: `addi` takes 4 cycles (FETCH→DECODE→EXEC→WB); `bne` takes 4 cycles (FETCH→DECODE→EXEC→BRANCH). The next FETCH follows immediately.
- Exactly one `PCWrite` pulse per retired instruction; at most one `RegWrite` pulse per `addi`; `RegWrite` is never asserted for `bne`.
- `en` is ignored outside FETCH: an instruction already in flight always completes.
- Reset mid-instruction (any state): no strobe is asserted in the reset cycle; state returns to FETCH and the in-flight instruction is not retired.
- `instr` changing outside FETCH has no effect.

## Structure
- Package `ctrl_pkg`:
  - state enum `ctrl_state_t`;
  - instruction class enum `icls_t` {ADDI, BNE, ILL};
  - constants `OP_IMM=7'b0010011`, `OP_BRANCH=7'b1100011`, `F3_ADDI=3'b000`, `F3_BNE=3'b001`.
- Sub-module `instr_classify`: combinational IR → `icls_t`. Its output is registered in DECODE.
- Top-level module contains the FSM, IR, `eq_q`, `illegal` and the `retired` counter.

## Test plan
- Reset, then `en`=1 with `instr`=`0x00500093` (addi x1,x0,5) → IR=`0x00500093`; WB cycle 4 shows `RegWrite`=1, `PCWrite`=1, `PCsrc`=0; `retired`=1.
- `instr`=`0xFE209EE3` (bne x1,x2,-4):
  - `EQ`=0 in EXEC → BRANCH has `PCsrc`=1, `RegWrite`=0.
  - Repeat with `EQ`=1 → `PCsrc`=0.
- `instr`=`0x00000033` (add, unsupported) → `illegal`=1 from the cycle after DECODE; no strobes thereafter; `retired` frozen; `rst` clears.
- `en`=0 for 5 cycles in FETCH → IR unchanged, no strobes. Deassert `en` during EXEC → instruction still retires.
- Assert `rst` during EXEC of `addi` → no `RegWrite`/`PCWrite`; FETCH on the next cycle; `retired` unchanged (0 after reset).
- Preload `retired` to all-ones via a run of 2^CNT_WIDTH instructions (bench with `CNT_WIDTH`=4, 16 instructions) → wraps to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle addi/bne control unit.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ADDI = 2'd0,
        BNE  = 2'd1,
        ILL  = 2'd2
    } icls_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

endpackage

// File: rtl/instr_classify.sv
// Combinational instruction classifier: opcode/funct3 fields to instruction class.
module instr_classify
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output icls_t      icls
);

    // Only addi and bne are supported; everything else is flagged illegal.
    always_comb begin
        icls = ILL;
        if ((opcode == OP_IMM) && (funct3 == F3_ADDI)) begin
            icls = ADDI;
        end else if ((opcode == OP_BRANCH) && (funct3 == F3_BNE)) begin
            icls = BNE;
        end else begin
            icls = ILL;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for addi/bne: owns IR, branch flag, illegal flag and
// the retired-instruction counter. Outputs are registered alongside the state.
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  EQ,
    output logic [DATA_WIDTH-1:0] IR,
    output logic                  ALUctrl,
    output logic                  ALUsrc,
    output logic                  ImmSrc,
    output logic                  RegWrite,
    output logic                  PCWrite,
    output logic                  PCsrc,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  retired
);

    ctrl_state_t           state_q, state_d;
    icls_t                 icls_q, icls_d, icls_dec_s;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;
    logic                  eq_q, eq_d;
    logic                  illegal_q, illegal_d;
    logic                  alu_ctrl_q, alu_ctrl_d;
    logic                  alu_src_q, alu_src_d;
    logic                  imm_src_q, imm_src_d;
    logic                  reg_write_q, reg_write_d;
    logic                  pc_write_q, pc_write_d;
    logic                  pc_src_q, pc_src_d;
    logic                  ir_write_s;

    instr_classify u_classify (
        .opcode (ir_q[6:0]),
        .funct3 (ir_q[14:12]),
        .icls   (icls_dec_s)
    );

    assign ir_write_s = (state_q == FETCH) && en && !rst;

    // Next-state logic; output values are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        icls_d      = icls_q;
        eq_d        = eq_q;
        illegal_d   = illegal_q;
        alu_ctrl_d  = 1'b0;
        alu_src_d   = 1'b0;
        imm_src_d   = 1'b0;
        reg_write_d = 1'b0;
        pc_write_d  = 1'b0;
        pc_src_d    = 1'b0;
        retired_d   = retired_q + {{(CNT_WIDTH-1){1'b0}}, pc_write_q};
        case (state_q)
            FETCH: begin
                if (ir_write_s) begin
                    ir_d    = instr;
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                icls_d = icls_dec_s;
                if (icls_dec_s == ILL) begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end else if (icls_dec_s == ADDI) begin
                    alu_ctrl_d = 1'b1;
                    alu_src_d  = 1'b1;
                    state_d    = EXEC;
                end else begin
                    imm_src_d = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (icls_q == BNE) begin
                    // PCsrc in BRANCH is the inverse of the flag captured here.
                    eq_d       = EQ;
                    pc_write_d = 1'b1;
                    pc_src_d   = ~EQ;
                    imm_src_d  = 1'b1;
                    state_d    = BRANCH;
                end else begin
                    reg_write_d = 1'b1;
                    pc_write_d  = 1'b1;
                    alu_ctrl_d  = 1'b1;
                    alu_src_d   = 1'b1;
                    state_d     = WB;
                end
            end
            WB:      state_d = FETCH;
            BRANCH:  state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // State, instruction, flags, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            icls_q      <= ADDI;
            ir_q        <= {DATA_WIDTH{1'b0}};
            eq_q        <= 1'b0;
            illegal_q   <= 1'b0;
            retired_q   <= {CNT_WIDTH{1'b0}};
            alu_ctrl_q  <= 1'b0;
            alu_src_q   <= 1'b0;
            imm_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            pc_write_q  <= 1'b0;
            pc_src_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            icls_q      <= icls_d;
            ir_q        <= ir_d;
            eq_q        <= eq_d;
            illegal_q   <= illegal_d;
            retired_q   <= retired_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_src_q   <= alu_src_d;
            imm_src_q   <= imm_src_d;
            reg_write_q <= reg_write_d;
            pc_write_q  <= pc_write_d;
            pc_src_q    <= pc_src_d;
        end
    end

    // Reset masks the controls immediately so a WB/BRANCH cycle cut by reset writes nothing.
    assign ALUctrl  = alu_ctrl_q  & ~rst;
    assign ALUsrc   = alu_src_q   & ~rst;
    assign ImmSrc   = imm_src_q   & ~rst;
    assign RegWrite = reg_write_q & ~rst;
    assign PCWrite  = pc_write_q  & ~rst;
    assign PCsrc    = pc_src_q    & ~rst;
    assign IR       = ir_q;
    assign illegal  = illegal_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed and randomized addi/bne/illegal
// sequences compared against a per-instruction behavioural model.
module tb_mc_ctrl_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [31:0]   instr;
    logic          EQ;
    logic [31:0]   IR;
    logic          ALUctrl, ALUsrc, ImmSrc, RegWrite, PCWrite, PCsrc, illegal;
    logic [CW-1:0] retired;

    int errors = 0;
    int checks = 0;
    int exp_ret = 0;
    logic [31:0] exp_ir = 32'd0;

    mc_ctrl_fsm #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .EQ(EQ), .IR(IR),
        .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .PCWrite(PCWrite), .PCsrc(PCsrc), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rw, input logic pw, input logic ps,
                           input logic ac, input logic as_, input logic is_);
        chk({tag, "_RegWrite"}, {31'd0, RegWrite}, {31'd0, rw});
        chk({tag, "_PCWrite"},  {31'd0, PCWrite},  {31'd0, pw});
        chk({tag, "_PCsrc"},    {31'd0, PCsrc},    {31'd0, ps});
        chk({tag, "_ALUctrl"},  {31'd0, ALUctrl},  {31'd0, ac});
        chk({tag, "_ALUsrc"},   {31'd0, ALUsrc},   {31'd0, as_});
        chk({tag, "_ImmSrc"},   {31'd0, ImmSrc},   {31'd0, is_});
    endtask

    // 0 = addi, 1 = bne, 2 = unsupported
    function automatic int model_class(input logic [31:0] w);
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) return 0;
        if (w[6:0] == 7'b1100011 && w[14:12] == 3'b001) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] rand_addi();
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = 7'b0010011;
        w[14:12] = 3'b000;
        return w;
    endfunction

    function automatic logic [31:0] rand_bne();
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = 7'b1100011;
        w[14:12] = 3'b001;
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        exp_ret = 0;
        exp_ir  = 32'd0;
        chk("rst_IR", IR, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_retired", {28'd0, retired}, 32'd0);
        chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Runs one instruction from FETCH; unsupported words halt and are reset out.
    task automatic run_instr(input logic [31:0] word, input logic eqv, input int stall);
        int  cls;
        logic is_addi, is_bne;
        cls = model_class(word);
        is_addi = (cls == 0);
        is_bne  = (cls == 1);
        for (int k = 0; k < stall; k++) begin
            en = 1'b0;
            instr = $urandom;
            chk("stall_IR", IR, exp_ir);
            chk_out("stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        en = 1'b1;
        instr = word;
        chk_out("fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        exp_ir = word;
        chk("decode_IR", IR, exp_ir);
        chk_out("decode", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'($urandom);
        instr = $urandom;
        EQ = 1'($urandom);
        tick();
        if (cls == 2) begin
            for (int k = 0; k < 4; k++) begin
                chk("halt_illegal", {31'd0, illegal}, 32'd1);
                chk("halt_retired", {28'd0, retired}, exp_ret);
                chk_out("halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                en = 1'b1;
                instr = rand_addi();
                tick();
            end
            do_reset();
            return;
        end
        chk("exec_illegal", {31'd0, illegal}, 32'd0);
        chk_out("exec", 1'b0, 1'b0, 1'b0, is_addi, is_addi, is_bne);
        EQ = eqv;
        en = 1'($urandom);
        tick();
        EQ = ~eqv;
        instr = $urandom;
        chk_out(is_addi ? "wb" : "branch", is_addi, 1'b1, is_bne && !eqv, is_addi, is_addi, is_bne);
        chk("pre_retired", {28'd0, retired}, exp_ret);
        tick();
        exp_ret = (exp_ret + 1) % (1 << CW);
        chk("retired", {28'd0, retired}, exp_ret);
        chk("after_IR", IR, exp_ir);
    endtask

    // Starts an addi and asserts reset in EXEC (phase 2) or WB (phase 3).
    task automatic rst_mid(input int phase);
        en = 1'b1;
        instr = 32'h00500093;
        tick();
        en = 1'b0;
        tick();
        if (phase == 3) tick();
        rst = 1'b1;
        #1;
        chk_out("rstmid_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        exp_ret = 0;
        exp_ir  = 32'd0;
        chk("rstmid_IR", IR, 32'd0);
        chk("rstmid_retired", {28'd0, retired}, 32'd0);
        chk_out("rstmid_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rstmid_retired2", {28'd0, retired}, 32'd0);
        chk_out("rstmid_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h00500093, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        instr = 32'd0;
        EQ = 1'b0;
        do_reset();

        run_instr(32'h00500093, 1'b0, 0);
        run_instr(32'hFE209EE3, 1'b0, 0);
        run_instr(32'hFE209EE3, 1'b1, 0);
        run_instr(32'h00000033, 1'b0, 0);
        run_instr(32'h00500093, 1'b1, 5);

        rst_mid(2);
        rst_mid(3);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_instr(rand_addi(), 1'($urandom), 0);
        end
        chk("wrap_retired", {28'd0, retired}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            int sel;
            logic [31:0] w;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      w = rand_addi();
            else if (sel < 8) w = rand_bne();
            else              w = $urandom;
            run_instr(w, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
